mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter multiplexing up to four cores onto one memory port.
// Single outstanding transaction; command, grant and completion are all registered.
module mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_req,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [NUM_MASTERS*32-1:0]     m_wdata,
    output logic [NUM_MASTERS-1:0]        m_ready,
    output logic [31:0]                   m_rdata,
    output logic                          s_req,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [31:0]                   s_wdata,
    input  logic                          s_ready,
    input  logic [31:0]                   s_rdata,
    output logic [1:0]                    grant_id,
    output logic                          busy
);

    localparam int unsigned NM   = NUM_MASTERS;
    localparam logic [1:0]  LAST = 2'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_ptr;
    logic [1:0]             r_grant;
    logic                   r_busy;
    logic                   r_s_req;
    logic                   r_s_we;
    logic [ADDR_W-1:0]      r_s_addr;
    logic [31:0]            r_s_wdata;
    logic [NUM_MASTERS-1:0] r_ready;
    logic [31:0]            r_rdata;

    // Per-core lanes padded to four so the 2-bit grant index is always in range.
    logic [3:0]        w_req;
    logic [3:0]        w_we;
    logic [ADDR_W-1:0] w_addr  [4];
    logic [31:0]       w_wdata [4];

    for (genvar g = 0; g < 4; g++) begin : g_lane
        if (g < NUM_MASTERS) begin : g_real
            assign w_req[g]   = m_req[g];
            assign w_we[g]    = m_we[g];
            assign w_addr[g]  = m_addr[g*ADDR_W +: ADDR_W];
            assign w_wdata[g] = m_wdata[g*32 +: 32];
        end else begin : g_pad
            assign w_req[g]   = 1'b0;
            assign w_we[g]    = 1'b0;
            assign w_addr[g]  = '0;
            assign w_wdata[g] = '0;
        end
    end

    logic       w_any;
    logic [1:0] w_winner;
    logic [2:0] w_idx;
    logic [1:0] w_next;
    logic [3:0] w_grant_oh;

    // First requester found scanning upward from the priority pointer, with wrap.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            w_idx = 3'(r_ptr) + 3'(k);
            if (w_idx >= 3'(NM)) begin
                w_idx = w_idx - 3'(NM);
            end
            if (!w_any && w_req[w_idx[1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_idx[1:0];
            end
        end
    end

    assign w_next     = (w_winner == LAST) ? 2'd0 : w_winner + 2'd1;
    assign w_grant_oh = 4'b0001 << r_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_s_req   <= 1'b0;
            r_s_we    <= 1'b0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_ready   <= '0;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= '0;
                    if (w_any) begin
                        r_s_req   <= 1'b1;
                        r_s_we    <= w_we[w_winner];
                        r_s_addr  <= w_addr[w_winner];
                        r_s_wdata <= w_wdata[w_winner];
                        r_grant   <= w_winner;
                        r_ptr     <= w_next;
                        r_busy    <= 1'b1;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        r_s_req <= 1'b0;
                        if (!r_s_we) begin
                            r_rdata <= s_rdata;
                        end
                        r_ready <= w_grant_oh[NUM_MASTERS-1:0];
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_ready <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_ready  = r_ready;
    assign m_rdata  = r_rdata;
    assign s_req    = r_s_req;
    assign s_we     = r_s_we;
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign grant_id = r_grant;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (four cores): transaction-level reference model
// compared every cycle, plus literal expectations for latency, grant order and reset.
module tb_mem_arbiter;

    localparam int NM = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  c_req;
    logic [3:0]  c_we;
    logic [31:0] c_addr  [4];
    logic [31:0] c_wdata [4];
    logic [127:0] m_addr_bus;
    logic [127:0] m_wdata_bus;
    logic [3:0]  m_ready;
    logic [31:0] m_rdata;
    logic        s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant_id;
    logic        busy;

    assign m_addr_bus  = {c_addr[3], c_addr[2], c_addr[1], c_addr[0]};
    assign m_wdata_bus = {c_wdata[3], c_wdata[2], c_wdata[1], c_wdata[0]};

    mem_arbiter #(.NUM_MASTERS(NM), .ADDR_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (c_req),
        .m_we     (c_we),
        .m_addr   (m_addr_bus),
        .m_wdata  (m_wdata_bus),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_ready  (s_ready),
        .s_rdata  (s_rdata),
        .grant_id (grant_id),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory responder: automatic fixed latency, or manual pulses from the stimulus.
    bit          mem_auto   = 1'b1;
    int          mem_lat    = 1;
    bit          mem_fixed  = 1'b0;
    logic [31:0] mem_val    = '0;
    logic        man_sready = 1'b0;
    logic [31:0] man_rdata  = '0;
    int          mcnt       = 0;

    initial begin
        s_ready = 1'b0;
        s_rdata = '0;
    end

    always @(posedge clk) begin
        #1;
        if (!mem_auto) begin
            s_ready = man_sready;
            s_rdata = man_rdata;
            mcnt    = 0;
        end else if (s_ready) begin
            s_ready = 1'b0;
            mcnt    = 0;
        end else if (s_req) begin
            mcnt++;
            if (mcnt >= mem_lat) begin
                s_ready = 1'b1;
                s_rdata = mem_fixed ? mem_val : (s_addr ^ 32'h5A5A_0000);
            end
        end else begin
            mcnt = 0;
        end
    end

    // Reference model: at most one transaction in flight; completion is visible for
    // exactly one cycle after the memory answers, arbitration only when nothing is open.
    bit          md_act   = 1'b0;
    bit          md_done  = 1'b0;
    bit          found;
    int          mp       = 0;
    int          mg       = 0;
    int          mc;
    logic        me_sreq  = 1'b0;
    logic        me_we    = 1'b0;
    logic [31:0] me_addr  = '0;
    logic [31:0] me_wdata = '0;
    logic [31:0] me_rdata = '0;
    logic [3:0]  me_ready = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_act = 1'b0; md_done = 1'b0; mp = 0; mg = 0;
            me_sreq = 1'b0; me_we = 1'b0; me_addr = '0; me_wdata = '0;
            me_rdata = '0; me_ready = '0;
        end else if (md_done) begin
            md_done  = 1'b0;
            me_ready = '0;
        end else if (md_act) begin
            if (s_ready) begin
                md_act  = 1'b0;
                md_done = 1'b1;
                me_sreq = 1'b0;
                if (!me_we) me_rdata = s_rdata;
                me_ready = 4'(1 << mg);
            end
        end else begin
            found = 1'b0;
            for (int k = 0; k < NM; k++) begin
                mc = (mp + k) % NM;
                if (!found && c_req[mc]) begin
                    found = 1'b1;
                    mg    = mc;
                end
            end
            if (found) begin
                mp       = (mg + 1) % NM;
                md_act   = 1'b1;
                me_sreq  = 1'b1;
                me_we    = c_we[mg];
                me_addr  = c_addr[mg];
                me_wdata = c_wdata[mg];
            end
        end
    end

    int   gq[$];
    logic prev_sreq = 1'b0;

    always @(negedge clk) begin
        chk("cyc_s_req",    32'(s_req),    32'(me_sreq));
        chk("cyc_s_we",     32'(s_we),     32'(me_we));
        chk("cyc_s_addr",   s_addr,        me_addr);
        chk("cyc_s_wdata",  s_wdata,       me_wdata);
        chk("cyc_m_ready",  32'(m_ready),  32'(me_ready));
        chk("cyc_m_rdata",  m_rdata,       me_rdata);
        chk("cyc_busy",     32'(busy),     32'(md_act || md_done));
        if (md_act || md_done)
            chk("cyc_grant_id", 32'(grant_id), 32'(mg));
        if (s_req && !prev_sreq) gq.push_back(int'(grant_id));
        prev_sreq = s_req;
    end

    function automatic int gq_at(input int i);
        if (i < gq.size()) return gq[i];
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input string nm, output int cyc);
        cyc = 0;
        while (m_ready == '0 && cyc < 40) begin
            step();
            cyc++;
        end
        chk(nm, 32'(m_ready != '0), 32'd1);
    endtask

    task automatic wait_sreq(input string nm);
        int n = 0;
        while (!s_req && n < 20) begin
            step();
            n++;
        end
        chk(nm, 32'(s_req), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    task automatic txn_complete(input bit twice, input logic [3:0] er,
                                input logic [31:0] ed, input string nm);
        man_sready = 1'b1;
        step();
        if (!twice) man_sready = 1'b0;
        step();
        man_sready = 1'b0;
        chk({nm, "_ready"}, 32'(m_ready), 32'(er));
        chk({nm, "_rdata"}, m_rdata, ed);
    endtask

    int cyc;
    int base;
    int n;
    int cnt [4];

    initial begin
        rst   = 1'b0;
        c_req = '0;
        c_we  = '0;
        for (int i = 0; i < 4; i++) begin
            c_addr[i]  = 32'h1000 + 32'(i * 4);
            c_wdata[i] = 32'h0;
        end
        #1 rst = 1'b1;
        #1;
        chk("rst_s_req",  32'(s_req),   32'd0);
        chk("rst_busy",   32'(busy),    32'd0);
        chk("rst_grant",  32'(grant_id), 32'd0);
        chk("rst_ready",  32'(m_ready), 32'd0);
        chk("rst_rdata",  m_rdata,      32'd0);
        chk("rst_s_addr", s_addr,       32'd0);
        step();
        step();
        rst = 1'b0;

        // Single load, memory answers three cycles after the request
        mem_lat   = 3;
        mem_fixed = 1'b1;
        mem_val   = 32'hCAFE_F00D;
        c_addr[0] = 32'h100;
        c_we[0]   = 1'b0;
        c_req[0]  = 1'b1;
        wait_ready("t1_wait", cyc);
        chk("t1_latency", 32'(cyc),     32'd4);
        chk("t1_ready",   32'(m_ready), 32'h1);
        chk("t1_rdata",   m_rdata,      32'hCAFE_F00D);
        chk("t1_s_addr",  s_addr,       32'h100);
        chk("t1_s_we",    32'(s_we),    32'd0);
        c_req[0] = 1'b0;
        step();
        chk("t1_pulse_end", 32'(m_ready), 32'd0);

        // Store from core 1; its inputs change while the command is outstanding
        mem_lat    = 2;
        mem_val    = 32'hFFFF_0000;
        c_we[1]    = 1'b1;
        c_addr[1]  = 32'h200;
        c_wdata[1] = 32'h1234_5678;
        c_req[1]   = 1'b1;
        step();
        chk("t2_s_we",    32'(s_we),     32'd1);
        chk("t2_s_wdata", s_wdata,       32'h1234_5678);
        chk("t2_s_addr",  s_addr,        32'h200);
        chk("t2_grant",   32'(grant_id), 32'd1);
        c_addr[1]  = 32'hDEAD;
        c_wdata[1] = 32'h0;
        c_we[1]    = 1'b0;
        wait_ready("t2_wait", cyc);
        chk("t2_ready",      32'(m_ready), 32'h2);
        chk("t2_rdata_kept", m_rdata,      32'hCAFE_F00D);
        chk("t2_s_addr_hold", s_addr,      32'h200);
        c_req[1]  = 1'b0;
        c_addr[1] = 32'h1004;

        // Cores 0 and 1 contend continuously; pointer starts at core 2
        mem_fixed = 1'b0;
        mem_lat   = 1;
        base      = gq.size();
        c_req     = 4'b0011;
        n = 0;
        while (gq.size() < base + 4 && n < 60) begin
            step();
            n++;
        end
        c_req = '0;
        chk("t3_g0", 32'(gq_at(base)),     32'd0);
        chk("t3_g1", 32'(gq_at(base + 1)), 32'd1);
        chk("t3_g2", 32'(gq_at(base + 2)), 32'd0);
        chk("t3_g3", 32'(gq_at(base + 3)), 32'd1);
        wait_idle("t3_idle");

        // Reset restores core 0 priority; then all four compete for 12 rounds
        rst = 1'b1;
        #1;
        chk("t4_rst_s_req", 32'(s_req), 32'd0);
        c_req = 4'b1111;
        step();
        rst  = 1'b0;
        base = gq.size();
        n = 0;
        while (gq.size() < base + 12 && n < 100) begin
            step();
            n++;
        end
        c_req = '0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t4_order%0d", i), 32'(gq_at(base + i)), 32'(i % 4));
            if (gq_at(base + i) >= 0 && gq_at(base + i) < 4) cnt[gq_at(base + i)]++;
        end
        for (int i = 0; i < 4; i++) chk($sformatf("t4_count%0d", i), 32'(cnt[i]), 32'd3);
        wait_idle("t4_idle");

        // Reset while core 2 is waiting on memory
        mem_auto   = 1'b0;
        man_sready = 1'b0;
        c_req      = 4'b0100;
        wait_sreq("t5_sreq");
        chk("t5_grant2", 32'(grant_id), 32'd2);
        c_req[0] = 1'b1;
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_s_req", 32'(s_req),    32'd0);
        chk("t5_rst_ready", 32'(m_ready),  32'd0);
        chk("t5_rst_busy",  32'(busy),     32'd0);
        chk("t5_rst_grant", 32'(grant_id), 32'd0);
        step();
        rst = 1'b0;
        wait_sreq("t5_resume");
        chk("t5_grant0", 32'(grant_id), 32'd0);
        c_req[0]  = 1'b0;
        man_rdata = 32'hA5A5_0000;
        txn_complete(1'b0, 4'b0001, 32'hA5A5_0000, "t5_done");

        // Core 2 next; memory holds s_ready into the completion cycle
        wait_sreq("t6_sreq");
        chk("t6_grant2", 32'(grant_id), 32'd2);
        c_req[2]  = 1'b0;
        man_rdata = 32'h0000_BEEF;
        txn_complete(1'b1, 4'b0100, 32'h0000_BEEF, "t6_done");

        // Spurious memory completion while idle
        step();
        man_rdata  = 32'h0000_0BAD;
        man_sready = 1'b1;
        step();
        man_sready = 1'b0;
        step();
        step();
        chk("t7_busy",  32'(busy),    32'd0);
        chk("t7_ready", 32'(m_ready), 32'd0);
        chk("t7_rdata", m_rdata,      32'h0000_BEEF);
        chk("t7_s_req", 32'(s_req),   32'd0);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

endmodule
